// File: rtl/gray_sweep_ctrl.sv
// Sweeps a 4-bit Gray up/down counter from FIRST to LAST with dwell and pass count, checking Q feedback.
// Outputs decode the registered state; the counter sees CNT_* at the edge leaving a state.
module gray_sweep_ctrl #(
  parameter int LOOP_W  = 4,
  parameter int DWELL_W = 4
) (
  input  logic               CLK,
  input  logic               CS,
  input  logic               START,
  input  logic               ABORT,
  input  logic               DIR,
  input  logic [3:0]         FIRST,
  input  logic [3:0]         LAST,
  input  logic [LOOP_W-1:0]  LOOPS,
  input  logic [DWELL_W-1:0] DWELL,
  input  logic [3:0]         Q,
  output logic               CNT_LD,
  output logic               CNT_EN,
  output logic               CNT_DNUP,
  output logic               CNT_CS,
  output logic [3:0]         CNT_D,
  output logic               BUSY,
  output logic               DONE,
  output logic               ERR
);

  typedef enum logic [2:0] {
    IDLE, LOAD, CHECK, WAIT, STEP, FIN, FAULT, KILL
  } state_t;

  state_t             state;
  logic [3:0]         first_q;
  logic [3:0]         last_q;
  logic               dir_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [LOOP_W-1:0]  loop_cnt;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [3:0]         exp_code;

  // Step through binary so both directions share one incrementer.
  function automatic logic [3:0] gray_next(input logic [3:0] g, input logic down);
    logic [3:0] b;
    b[3] = g[3];
    b[2] = b[3] ^ g[2];
    b[1] = b[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    b = down ? b - 4'd1 : b + 4'd1;
    return b ^ (b >> 1);
  endfunction

  always_ff @(posedge CLK) begin
    if (CS) begin
      state     <= IDLE;
      first_q   <= '0;
      last_q    <= '0;
      dir_q     <= 1'b0;
      dwell_q   <= '0;
      loop_cnt  <= '0;
      dwell_cnt <= '0;
      exp_code  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            first_q  <= FIRST;
            last_q   <= LAST;
            dir_q    <= DIR;
            dwell_q  <= DWELL;
            loop_cnt <= LOOPS;
            state    <= (LOOPS == '0) ? FIN : LOAD;
          end
        end
        LOAD: begin
          if (ABORT) begin
            state <= KILL;
          end else begin
            exp_code <= first_q;
            state    <= CHECK;
          end
        end
        CHECK: begin
          // Abort outranks both a mismatch and pass completion.
          if (ABORT) begin
            state <= KILL;
          end else if (Q != exp_code) begin
            state <= FAULT;
          end else if (exp_code == last_q) begin
            loop_cnt <= loop_cnt - LOOP_W'(1);
            state    <= (loop_cnt == LOOP_W'(1)) ? FIN : LOAD;
          end else if (dwell_q == '0) begin
            state <= STEP;
          end else begin
            dwell_cnt <= dwell_q;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (ABORT) begin
            state <= KILL;
          end else begin
            dwell_cnt <= dwell_cnt - DWELL_W'(1);
            if (dwell_cnt == DWELL_W'(1)) state <= STEP;
          end
        end
        STEP: begin
          if (ABORT) begin
            state <= KILL;
          end else begin
            exp_code <= gray_next(exp_code, dir_q);
            state    <= CHECK;
          end
        end
        FIN, FAULT, KILL: state <= IDLE;
        default:          state <= IDLE;
      endcase
    end
  end

  assign BUSY     = (state != IDLE);
  assign CNT_LD   = (state == LOAD);
  assign CNT_EN   = (state == STEP);
  assign CNT_CS   = (state == FAULT) || (state == KILL);
  assign DONE     = (state == FIN);
  assign ERR      = (state == FAULT);
  assign CNT_DNUP = BUSY & dir_q;
  assign CNT_D    = BUSY ? first_q : 4'b0000;

endmodule

// File: tb/tb_gray_sweep_ctrl.sv
// Bench for gray_sweep_ctrl: pairs it with a table-driven Gray counter model and
// compares every cycle of each sweep against a queue of expected output words.
module tb_gray_sweep_ctrl;

  logic       clk = 1'b0;
  logic       cs, start, abort, dir;
  logic [3:0] first, last;
  logic [3:0] loops, dwell;
  logic [3:0] q = 4'b0000;
  logic       cnt_ld, cnt_en, cnt_dnup, cnt_cs, busy, done, err;
  logic [3:0] cnt_d;

  int tests = 0;
  int fails = 0;
  int ign_en = 0;
  int en_seen = 0;

  always #5 clk = ~clk;

  gray_sweep_ctrl #(.LOOP_W(4), .DWELL_W(4)) dut (
    .CLK(clk), .CS(cs), .START(start), .ABORT(abort), .DIR(dir),
    .FIRST(first), .LAST(last), .LOOPS(loops), .DWELL(dwell), .Q(q),
    .CNT_LD(cnt_ld), .CNT_EN(cnt_en), .CNT_DNUP(cnt_dnup), .CNT_CS(cnt_cs),
    .CNT_D(cnt_d), .BUSY(busy), .DONE(done), .ERR(err)
  );

  logic [3:0] gtab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                            4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  function automatic int gpos(input logic [3:0] g);
    for (int i = 0; i < 16; i++) if (gtab[i] == g) return i;
    return 0;
  endfunction

  // Behavioural counter; ign_en selects which EN since the last load is dropped.
  always @(posedge clk) begin
    if (cnt_cs) begin
      q <= 4'b0000;
    end else if (cnt_ld) begin
      q       <= cnt_d;
      en_seen <= 0;
    end else if (cnt_en) begin
      en_seen <= en_seen + 1;
      if (en_seen + 1 != ign_en)
        q <= gtab[(gpos(q) + (cnt_dnup ? 15 : 1)) % 16];
    end
  end

  typedef struct packed {
    logic [10:0] o;
    logic        qv;
    logic [3:0]  q;
  } exp_t;

  exp_t sb[$];

  task automatic push(input logic [10:0] o, input logic qv, input logic [3:0] qe);
    exp_t e;
    e.o  = o;
    e.qv = qv;
    e.q  = qe;
    sb.push_back(e);
  endtask

  // Output word: {BUSY, LD, EN, DNUP, CS, DONE, ERR, D}
  task automatic build(input logic [3:0] f, input logic [3:0] l, input logic dr,
                       input int nloops, input int dw);
    int n, idx;
    n = dr ? (gpos(f) - gpos(l) + 16) % 16 : (gpos(l) - gpos(f) + 16) % 16;
    for (int p = 0; p < nloops; p++) begin
      idx = gpos(f);
      push({1'b1, 1'b1, 1'b0, dr, 1'b0, 1'b0, 1'b0, f}, 1'b0, 4'h0);
      push({1'b1, 1'b0, 1'b0, dr, 1'b0, 1'b0, 1'b0, f}, 1'b1, gtab[idx]);
      for (int s = 0; s < n; s++) begin
        for (int w = 0; w < dw; w++)
          push({1'b1, 1'b0, 1'b0, dr, 1'b0, 1'b0, 1'b0, f}, 1'b1, gtab[idx]);
        push({1'b1, 1'b0, 1'b1, dr, 1'b0, 1'b0, 1'b0, f}, 1'b1, gtab[idx]);
        idx = dr ? (idx + 15) % 16 : (idx + 1) % 16;
        push({1'b1, 1'b0, 1'b0, dr, 1'b0, 1'b0, 1'b0, f}, 1'b1, gtab[idx]);
      end
    end
    push({1'b1, 1'b0, 1'b0, dr, 1'b0, 1'b1, 1'b0, f}, 1'b0, 4'h0);
    push(11'd0, 1'b0, 4'h0);
  endtask

  // mode: 0 clean, 1 drop 2nd EN, 2 abort at cycle 4, 3 reset at cycle 4, 4 hold START
  task automatic run(input string name, input logic [3:0] f, input logic [3:0] l,
                     input logic dr, input int nloops, input int dw, input int mode,
                     input int exp_done, input int exp_err, input int exp_ld, input int exp_en);
    int len, done_c, err_c, ld_n, en_n;
    exp_t e;
    logic [10:0] obs;
    sb.delete();
    build(f, l, dr, nloops, dw);
    if (mode == 1) begin
      while (sb.size() > 6) sb.delete(sb.size() - 1);
      e = sb[5]; e.q = 4'b0001; sb[5] = e;
      push({1'b1, 1'b0, 1'b0, dr, 1'b1, 1'b0, 1'b1, f}, 1'b0, 4'h0);
      push(11'd0, 1'b0, 4'h0);
    end else if (mode == 2) begin
      while (sb.size() > 4) sb.delete(sb.size() - 1);
      push({1'b1, 1'b0, 1'b0, dr, 1'b1, 1'b0, 1'b0, f}, 1'b0, 4'h0);
      push(11'd0, 1'b0, 4'h0);
    end else if (mode == 3) begin
      while (sb.size() > 4) sb.delete(sb.size() - 1);
      push(11'd0, 1'b0, 4'h0);
      push(11'd0, 1'b0, 4'h0);
    end
    ign_en = (mode == 1) ? 2 : 0;
    len = sb.size();
    done_c = -1; err_c = -1; ld_n = 0; en_n = 0;

    @(negedge clk);
    first = f; last = l; dir = dr; loops = 4'(nloops); dwell = 4'(dw);
    abort = 1'b0; cs = 1'b0; start = 1'b1;

    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      e   = sb.pop_front();
      obs = {busy, cnt_ld, cnt_en, cnt_dnup, cnt_cs, done, err, cnt_d};
      tests++;
      assert (obs === e.o) else begin
        fails++;
        $error("FAIL %s_out_c%0d observed=%b expected=%b", name, k, obs, e.o);
      end
      if (e.qv) begin
        tests++;
        assert (q === e.q) else begin
          fails++;
          $error("FAIL %s_q_c%0d observed=%b expected=%b", name, k, q, e.q);
        end
      end
      if (done && done_c < 0) done_c = k;
      if (err && err_c < 0) err_c = k;
      ld_n += int'(cnt_ld);
      en_n += int'(cnt_en);
      if (mode == 4) begin
        if (k == 3) begin
          first = 4'hF; last = 4'h5; dir = ~dr; loops = 4'h0; dwell = 4'h7;
        end
        if (k == len - 1) start = 1'b0;
      end else if (k == 1) begin
        start = 1'b0;
      end
      if (mode == 2) abort = (k == 4);
      if (mode == 3) cs = (k == 4);
    end

    tests++;
    assert (done_c === exp_done) else begin
      fails++; $error("FAIL %s_done_cycle observed=%0d expected=%0d", name, done_c, exp_done);
    end
    tests++;
    assert (err_c === exp_err) else begin
      fails++; $error("FAIL %s_err_cycle observed=%0d expected=%0d", name, err_c, exp_err);
    end
    tests++;
    assert (ld_n === exp_ld) else begin
      fails++; $error("FAIL %s_ld_count observed=%0d expected=%0d", name, ld_n, exp_ld);
    end
    tests++;
    assert (en_n === exp_en) else begin
      fails++; $error("FAIL %s_en_count observed=%0d expected=%0d", name, en_n, exp_en);
    end
  endtask

  initial begin
    logic [10:0] obs;
    cs = 1'b1; start = 1'b1; abort = 1'b1; dir = 1'b1;
    first = 4'h3; last = 4'h9; loops = 4'h2; dwell = 4'h1;
    repeat (2) @(negedge clk);
    obs = {busy, cnt_ld, cnt_en, cnt_dnup, cnt_cs, done, err, cnt_d};
    tests++;
    assert (obs === 11'd0) else begin
      fails++; $error("FAIL reset_outputs observed=%b expected=%b", obs, 11'd0);
    end
    cs = 1'b0; start = 1'b0; abort = 1'b0;

    run("up",        4'h0, 4'h2, 1'b0, 1,  0, 0, 9,  -1, 1,  3);
    run("down_wrap", 4'h1, 4'h8, 1'b1, 2,  0, 0, 13, -1, 2,  4);
    run("dwell",     4'h0, 4'h1, 1'b0, 1,  3, 0, 8,  -1, 1,  1);
    run("loops0",    4'h0, 4'h2, 1'b0, 0,  0, 0, 1,  -1, 0,  0);
    run("first_eq",  4'h6, 4'h6, 1'b0, 1,  0, 0, 3,  -1, 1,  0);
    run("loops_max", 4'h3, 4'h3, 1'b1, 15, 0, 0, 31, -1, 15, 0);
    run("fault",     4'h0, 4'h2, 1'b0, 1,  0, 1, -1, 7,  1,  2);
    run("post_fault",4'h0, 4'h2, 1'b0, 1,  0, 0, 9,  -1, 1,  3);
    run("abort",     4'h0, 4'h1, 1'b0, 1,  3, 2, -1, -1, 1,  0);
    run("reset_mid", 4'h0, 4'h2, 1'b0, 1,  0, 3, -1, -1, 1,  1);
    run("hold_start",4'h0, 4'h2, 1'b0, 1,  0, 4, 9,  -1, 1,  3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
